// File: rtl/fetch_stage_pkg.sv
// Shared fetch definitions: bubble encoding, reset vector default,
// FSM state encoding and the IF/ID slot bundle.
package fetch_stage_pkg;

    localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} holding register for a response that
// arrives while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] d_inst,
    input  logic [31:0] d_pc,
    output logic        q_valid,
    output logic [31:0] q_inst,
    output logic [31:0] q_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_inst  <= '0;
            q_pc    <= '0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_inst  <= d_inst;
            q_pc    <= d_pc;
        end else if (drain) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, sync imem request,
// registered IF/ID slot with stall skid and redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = DEF_NOP_INST
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misalign
);

    fetch_state_t state;
    if_id_t       slot;

    logic [31:0] pc_f;
    logic [31:0] req_pc;
    logic        inflight;
    logic        drop;
    logic        misalign;
    logic        issue;
    logic        rsp;
    logic        skid_v;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    assign issue = (state != BOOT) && !i_stall && !i_redirect;
    assign rsp   = inflight && !drop;

    assign o_imem_ren   = issue;
    assign o_imem_raddr = pc_f;

    fetch_skid_buf u_skid (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .load    (rsp && i_stall && !i_redirect),
        .drain   (skid_v && !i_stall && !i_redirect),
        .clear   (i_redirect),
        .d_inst  (i_imem_rdata),
        .d_pc    (req_pc),
        .q_valid (skid_v),
        .q_inst  (skid_inst),
        .q_pc    (skid_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= BOOT;
            pc_f     <= RESET_ADDR;
            req_pc   <= RESET_ADDR;
            inflight <= 1'b0;
            drop     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            unique case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (!i_redirect && i_stall && rsp)
                        state <= HOLD;
                end
                HOLD: begin
                    if (!i_stall || i_redirect)
                        state <= RUN;
                end
                default: state <= BOOT;
            endcase
            inflight <= issue;
            drop     <= i_redirect && inflight;
            misalign <= i_redirect && (|i_redirect_pc[1:0]);
            if (i_redirect) begin
                pc_f <= {i_redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                req_pc <= pc_f;
                pc_f   <= pc_f + 32'd4;
            end
        end
    end

    // Redirect beats stall; a full skid always drains before new data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot.valid    <= 1'b0;
            slot.inst     <= NOP_INST;
            slot.pc       <= '0;
            slot.pc_plus4 <= 32'd4;
        end else if (i_redirect) begin
            slot.valid <= 1'b0;
            slot.inst  <= NOP_INST;
        end else if (i_stall) begin
            slot <= slot;
        end else if (skid_v) begin
            slot.valid    <= 1'b1;
            slot.inst     <= skid_inst;
            slot.pc       <= skid_pc;
            slot.pc_plus4 <= skid_pc + 32'd4;
        end else if (rsp) begin
            slot.valid    <= 1'b1;
            slot.inst     <= i_imem_rdata;
            slot.pc       <= req_pc;
            slot.pc_plus4 <= req_pc + 32'd4;
        end else begin
            slot.valid <= 1'b0;
            slot.inst  <= NOP_INST;
        end
    end

    assign o_valid    = slot.valid;
    assign o_inst     = slot.inst;
    assign o_pc       = slot.pc;
    assign o_pc_plus4 = slot.pc_plus4;
    assign o_misalign = misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a 1-cycle sync memory
// whose word at address a is a ^ 32'hA5A5_0000.
module tb_fetch_stage;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_ren    (ren),
        .o_imem_raddr  (raddr),
        .i_imem_rdata  (rdata),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .o_inst        (inst),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren)
            rdata <= raddr ^ K;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_pc4"}, pc_plus4, 32'd4);
        chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_ren"}, {31'd0, ren}, 32'd0);
        chk({tag, "_raddr"}, raddr, 32'd0);
    endtask

    task automatic chk_slot(input string tag, input logic [31:0] epc);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
        chk({tag, "_pc"}, pc, epc);
        chk({tag, "_inst"}, inst, epc ^ K);
        chk({tag, "_pc4"}, pc_plus4, epc + 32'd4);
    endtask

    initial begin
        rdata       = '0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");

        // Boot cycle: no fetch
        rst_n = 1'b1;
        #1;
        chk("boot_ren", {31'd0, ren}, 32'd0);
        tick();
        chk("c1_ren", {31'd0, ren}, 32'd1);
        chk("c1_raddr", raddr, 32'h0);
        tick();
        chk("c2_raddr", raddr, 32'h4);
        chk("c2_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("c3_raddr", raddr, 32'h8);
        chk_slot("c3", 32'h0);
        tick();
        chk_slot("c4", 32'h4);
        tick();
        chk_slot("c5", 32'h8);
        chk("c5_raddr", raddr, 32'h10);
        tick();
        chk_slot("c6", 32'hC);

        // Three stall cycles with 0x10 in flight
        stall = 1'b1;
        #1;
        chk("st0_ren", {31'd0, ren}, 32'd0);
        tick();
        chk_slot("st1", 32'hC);
        chk("st1_ren", {31'd0, ren}, 32'd0);
        tick();
        chk_slot("st2", 32'hC);
        chk("st2_ren", {31'd0, ren}, 32'd0);
        tick();
        stall = 1'b0;
        #1;
        chk_slot("rel", 32'hC);
        chk("rel_ren", {31'd0, ren}, 32'd1);
        chk("rel_raddr", raddr, 32'h14);
        tick();
        chk_slot("drain", 32'h10);
        tick();
        chk_slot("after", 32'h14);

        // Redirect to 0x200 with 0x18 in flight
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("rd_ren", {31'd0, ren}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd_valid", {31'd0, valid}, 32'd0);
        chk("rd_inst", inst, NOP);
        chk("rd_ren1", {31'd0, ren}, 32'd1);
        chk("rd_raddr", raddr, 32'h200);
        tick();
        chk("rd_nostale", {31'd0, valid}, 32'd0);
        tick();
        chk_slot("rd_tgt", 32'h200);

        // Fill skid, then redirect+stall together
        stall = 1'b1;
        tick();
        chk_slot("sk_hold", 32'h200);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rs_valid", {31'd0, valid}, 32'd0);
        chk("rs_inst", inst, NOP);
        chk("rs_ren", {31'd0, ren}, 32'd1);
        chk("rs_raddr", raddr, 32'h300);
        tick();
        chk("rs_skidclr", {31'd0, valid}, 32'd0);
        tick();
        chk_slot("rs_tgt", 32'h300);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        #1;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_raddr", raddr, 32'h100);
        tick();
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        tick();
        chk_slot("mis_tgt", 32'h100);

        // PC wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        chk("wr_raddr0", raddr, 32'hFFFF_FFFC);
        tick();
        chk("wr_raddr1", raddr, 32'h0);
        tick();
        chk_slot("wr_slot", 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mrst");
        stall = 1'b0;
        #1;
        chk("mrst_ren", {31'd0, ren}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mboot_ren", {31'd0, ren}, 32'd0);
        tick();
        chk("mrun_ren", {31'd0, ren}, 32'd1);
        chk("mrun_raddr", raddr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
